sobel_matrix3_edge_detector: RTL and testbench

//  Downstream stage of the 3x3 grayscale matrix converter. Consumes each 8-neighbour matrix and its
//  top-left column/row, applies the 3x3 Sobel operator, emits one edge-magnitude pixel per matrix.
//  3-stage pipeline. Tracks raster order and flags out-of-sequence input. Pulses at frame completion.

---
 rtl/sobel_matrix3_edge_detector.sv | 230 +++++++++++++++++++++++
 tb/tb_sobel_matrix3_edge_detector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_matrix3_edge_detector.sv
// rtl/sobel_matrix3_edge_detector.sv - 3x3 Sobel edge-magnitude stage with raster sequence checking
//
// Purpose:
//   Takes one 8-neighbour 3x3 grayscale matrix per cycle, tagged with its
//   top-left column/row. Produces one edge-magnitude pixel, tagged with the
//   centre coordinate, exactly 3 cycles later. It also tracks raster order,
//   raises a sticky error on out-of-order input and pulses at the last pixel
//   of a frame.
//
// Optional feature macro: SOBEL_THRESHOLD_EN
//   When defined, the I_THRESHOLD port is present. O_PIXEL then becomes a
//   binary edge map: all-ones when |Gx|+|Gy| >= I_THRESHOLD, else 0.
//
// Ports:
//   I_CLK                 clock, all logic on posedge
//   I_RESET               synchronous active-high reset
//   I_PIXEL_COLUMN/ROW    top-left coordinate of the input matrix
//   I_PIXEL_MATRIX        {tl,t,tr,ml,mr,bl,b,br}, tl in the MSBs
//   I_PIXEL_MATRIX_READY  input valid, one matrix per cycle
//   I_THRESHOLD           (SOBEL_THRESHOLD_EN only) binary edge threshold
//   O_PIXEL_COLUMN/ROW    centre coordinate of the output pixel
//   O_PIXEL               edge magnitude, or binary edge
//   O_PIXEL_VALID         output qualifier
//   O_FRAME_DONE          1-cycle pulse with the last pixel of the frame
//   O_SEQ_ERROR           sticky out-of-raster-order flag

module sobel_matrix3_edge_detector #(
    parameter int P_FRAME_COLUMNS     = 640,
    parameter int P_FRAME_ROWS        = 480,
    parameter int P_SUBPIXEL_DEPTH    = 8,
    parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
    parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
    parameter int P_MATRIX_BITS       = 8 * P_SUBPIXEL_DEPTH
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET,
    input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
    input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
    input  logic [P_MATRIX_BITS-1:0]       I_PIXEL_MATRIX,
    input  logic                           I_PIXEL_MATRIX_READY,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [P_SUBPIXEL_DEPTH-1:0]    I_THRESHOLD,
`endif
    output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
    output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
    output logic [P_SUBPIXEL_DEPTH-1:0]    O_PIXEL,
    output logic                           O_PIXEL_VALID,
    output logic                           O_FRAME_DONE,
    output logic                           O_SEQ_ERROR
);

    localparam int D  = P_SUBPIXEL_DEPTH;
    localparam int CB = P_FRAME_COLUMN_BITS;
    localparam int RB = P_FRAME_ROW_BITS;
    // +/-4*(2^D-1) needs D+3 bits signed. |Gx|+|Gy| <= 8*(2^D-1) fits D+3 unsigned.
    localparam int GW = D + 3;

    localparam logic [CB-1:0] LAST_COL = CB'(P_FRAME_COLUMNS - 3);
    localparam logic [RB-1:0] LAST_ROW = RB'(P_FRAME_ROWS - 3);
    localparam logic [CB-1:0] ONE_C    = CB'(1);
    localparam logic [RB-1:0] ONE_R    = RB'(1);
    localparam logic [GW-1:0] ONE_G    = GW'(1);
    localparam logic [GW-1:0] MAX_G    = {3'b000, {D{1'b1}}};

    // Matrix unpack, tl in the MSBs
    logic [D-1:0] px_tl, px_t, px_tr, px_ml, px_mr, px_bl, px_b, px_br;
    assign px_tl = I_PIXEL_MATRIX[8*D-1 -: D];
    assign px_t  = I_PIXEL_MATRIX[7*D-1 -: D];
    assign px_tr = I_PIXEL_MATRIX[6*D-1 -: D];
    assign px_ml = I_PIXEL_MATRIX[5*D-1 -: D];
    assign px_mr = I_PIXEL_MATRIX[4*D-1 -: D];
    assign px_bl = I_PIXEL_MATRIX[3*D-1 -: D];
    assign px_b  = I_PIXEL_MATRIX[2*D-1 -: D];
    assign px_br = I_PIXEL_MATRIX[1*D-1 -: D];

    // Stage 1: gradients, held as two's complement in plain vectors
    logic          s1_valid_q, s1_valid_d;
    logic          s1_last_q,  s1_last_d;
    logic [GW-1:0] s1_gx_q,    s1_gx_d;
    logic [GW-1:0] s1_gy_q,    s1_gy_d;
    logic [CB-1:0] s1_col_q,   s1_col_d;
    logic [RB-1:0] s1_row_q,   s1_row_d;

    // Stage 2: magnitude sum
    logic          s2_valid_q, s2_valid_d;
    logic          s2_last_q,  s2_last_d;
    logic [GW-1:0] s2_sum_q,   s2_sum_d;
    logic [CB-1:0] s2_col_q,   s2_col_d;
    logic [RB-1:0] s2_row_q,   s2_row_d;
`ifdef SOBEL_THRESHOLD_EN
    logic [D-1:0]  s2_thr_q,   s2_thr_d;
`endif

    // Stage 3: registered outputs
    logic          o_valid_q,  o_valid_d;
    logic          o_done_q,   o_done_d;
    logic [D-1:0]  o_pixel_q,  o_pixel_d;
    logic [CB-1:0] o_col_q,    o_col_d;
    logic [RB-1:0] o_row_q,    o_row_d;

    // Sequence checker
    logic [CB-1:0] exp_col_q,  exp_col_d;
    logic [RB-1:0] exp_row_q,  exp_row_d;
    logic          seq_err_q,  seq_err_d;

    logic [GW-1:0] pos_x, neg_x, pos_y, neg_y;
    logic [GW-1:0] abs_x, abs_y;
    logic [D-1:0]  s3_value;
    logic          in_region;
    logic          coord_mismatch;

    always_comb begin
        // Stage 1
        pos_x = {3'b000, px_tr} + {2'b00, px_mr, 1'b0} + {3'b000, px_br};
        neg_x = {3'b000, px_tl} + {2'b00, px_ml, 1'b0} + {3'b000, px_bl};
        pos_y = {3'b000, px_bl} + {2'b00, px_b,  1'b0} + {3'b000, px_br};
        neg_y = {3'b000, px_tl} + {2'b00, px_t,  1'b0} + {3'b000, px_tr};

        in_region  = (I_PIXEL_COLUMN <= LAST_COL) && (I_PIXEL_ROW <= LAST_ROW);
        s1_valid_d = I_PIXEL_MATRIX_READY && in_region;
        s1_last_d  = (I_PIXEL_COLUMN == LAST_COL) && (I_PIXEL_ROW == LAST_ROW);
        s1_gx_d    = pos_x - neg_x;
        s1_gy_d    = pos_y - neg_y;
        s1_col_d   = I_PIXEL_COLUMN + ONE_C;
        s1_row_d   = I_PIXEL_ROW + ONE_R;

        // Stage 2
        abs_x      = s1_gx_q[GW-1] ? (~s1_gx_q + ONE_G) : s1_gx_q;
        abs_y      = s1_gy_q[GW-1] ? (~s1_gy_q + ONE_G) : s1_gy_q;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_sum_d   = abs_x + abs_y;
        s2_col_d   = s1_col_q;
        s2_row_d   = s1_row_q;
`ifdef SOBEL_THRESHOLD_EN
        s2_thr_d   = I_THRESHOLD;
`endif

        // Stage 3. Data outputs are forced to 0 whenever they are not valid.
`ifdef SOBEL_THRESHOLD_EN
        s3_value = (s2_sum_q >= {3'b000, s2_thr_q}) ? {D{1'b1}} : {D{1'b0}};
`else
        s3_value = (s2_sum_q > MAX_G) ? {D{1'b1}} : s2_sum_q[D-1:0];
`endif
        o_valid_d = s2_valid_q;
        o_done_d  = s2_valid_q && s2_last_q;
        o_pixel_d = s2_valid_q ? s3_value : {D{1'b0}};
        o_col_d   = s2_valid_q ? s2_col_q : {CB{1'b0}};
        o_row_d   = s2_valid_q ? s2_row_q : {RB{1'b0}};

        // Sequence checker. The expected position always follows the actual
        // input, so one bad coordinate raises only the sticky flag. An input
        // at (0,0) is a legal resync point at any time.
        exp_col_d      = exp_col_q;
        exp_row_d      = exp_row_q;
        seq_err_d      = seq_err_q;
        coord_mismatch = ((I_PIXEL_COLUMN != exp_col_q) || (I_PIXEL_ROW != exp_row_q)) &&
                         !((I_PIXEL_COLUMN == '0) && (I_PIXEL_ROW == '0));
        if (I_PIXEL_MATRIX_READY) begin
            if (coord_mismatch) begin
                seq_err_d = 1'b1;
            end
            if (I_PIXEL_COLUMN >= LAST_COL) begin
                exp_col_d = '0;
                exp_row_d = (I_PIXEL_ROW >= LAST_ROW) ? '0 : I_PIXEL_ROW + ONE_R;
            end else begin
                exp_col_d = I_PIXEL_COLUMN + ONE_C;
                exp_row_d = I_PIXEL_ROW;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_gx_q    <= '0;
            s1_gy_q    <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sum_q   <= '0;
            s2_col_q   <= '0;
            s2_row_q   <= '0;
`ifdef SOBEL_THRESHOLD_EN
            s2_thr_q   <= '0;
`endif
            o_valid_q  <= 1'b0;
            o_done_q   <= 1'b0;
            o_pixel_q  <= '0;
            o_col_q    <= '0;
            o_row_q    <= '0;
            exp_col_q  <= '0;
            exp_row_q  <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_gx_q    <= s1_gx_d;
            s1_gy_q    <= s1_gy_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_sum_q   <= s2_sum_d;
            s2_col_q   <= s2_col_d;
            s2_row_q   <= s2_row_d;
`ifdef SOBEL_THRESHOLD_EN
            s2_thr_q   <= s2_thr_d;
`endif
            o_valid_q  <= o_valid_d;
            o_done_q   <= o_done_d;
            o_pixel_q  <= o_pixel_d;
            o_col_q    <= o_col_d;
            o_row_q    <= o_row_d;
            exp_col_q  <= exp_col_d;
            exp_row_q  <= exp_row_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign O_PIXEL_COLUMN = o_col_q;
    assign O_PIXEL_ROW    = o_row_q;
    assign O_PIXEL        = o_pixel_q;
    assign O_PIXEL_VALID  = o_valid_q;
    assign O_FRAME_DONE   = o_done_q;
    assign O_SEQ_ERROR    = seq_err_q;

endmodule

// File: tb/tb_sobel_matrix3_edge_detector.sv
// tb/tb_sobel_matrix3_edge_detector.sv - directed self-checking bench for sobel_matrix3_edge_detector

module tb_sobel_matrix3_edge_detector;

    localparam int COLS = 16;
    localparam int ROWS = 10;
    localparam int D    = 8;
    localparam int CB   = 4;
    localparam int RB   = 4;
    localparam int MB   = 64;
    localparam int NCOL = COLS - 2;
    localparam int NROW = ROWS - 2;

    logic          I_CLK;
    logic          I_RESET;
    logic [CB-1:0] I_PIXEL_COLUMN;
    logic [RB-1:0] I_PIXEL_ROW;
    logic [MB-1:0] I_PIXEL_MATRIX;
    logic          I_PIXEL_MATRIX_READY;
`ifdef SOBEL_THRESHOLD_EN
    logic [D-1:0]  I_THRESHOLD;
`endif
    logic [CB-1:0] O_PIXEL_COLUMN;
    logic [RB-1:0] O_PIXEL_ROW;
    logic [D-1:0]  O_PIXEL;
    logic          O_PIXEL_VALID;
    logic          O_FRAME_DONE;
    logic          O_SEQ_ERROR;

    int thr = 1;
`ifdef SOBEL_THRESHOLD_EN
    assign I_THRESHOLD = 8'(thr);
`endif

    sobel_matrix3_edge_detector #(
        .P_FRAME_COLUMNS     (COLS),
        .P_FRAME_ROWS        (ROWS),
        .P_SUBPIXEL_DEPTH    (D),
        .P_FRAME_COLUMN_BITS (CB),
        .P_FRAME_ROW_BITS    (RB),
        .P_MATRIX_BITS       (MB)
    ) dut (
        .I_CLK                (I_CLK),
        .I_RESET              (I_RESET),
        .I_PIXEL_COLUMN       (I_PIXEL_COLUMN),
        .I_PIXEL_ROW          (I_PIXEL_ROW),
        .I_PIXEL_MATRIX       (I_PIXEL_MATRIX),
        .I_PIXEL_MATRIX_READY (I_PIXEL_MATRIX_READY),
`ifdef SOBEL_THRESHOLD_EN
        .I_THRESHOLD          (I_THRESHOLD),
`endif
        .O_PIXEL_COLUMN       (O_PIXEL_COLUMN),
        .O_PIXEL_ROW          (O_PIXEL_ROW),
        .O_PIXEL              (O_PIXEL),
        .O_PIXEL_VALID        (O_PIXEL_VALID),
        .O_FRAME_DONE         (O_FRAME_DONE),
        .O_SEQ_ERROR          (O_SEQ_ERROR)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
        cyc++;
    endtask

    task automatic drive(input int c, input int r, input logic [MB-1:0] m);
        I_PIXEL_COLUMN       = CB'(c);
        I_PIXEL_ROW          = RB'(r);
        I_PIXEL_MATRIX       = m;
        I_PIXEL_MATRIX_READY = 1'b1;
    endtask

    task automatic idle();
        I_PIXEL_MATRIX_READY = 1'b0;
    endtask

    task automatic do_reset();
        I_RESET = 1'b1;
        idle();
        tick();
        I_RESET = 1'b0;
    endtask

    function automatic logic [MB-1:0] pack(input int tl, input int t, input int tr, input int ml,
                                           input int mr, input int bl, input int b, input int br);
        return {8'(tl), 8'(t), 8'(tr), 8'(ml), 8'(mr), 8'(bl), 8'(b), 8'(br)};
    endfunction

    // Expected output for a given unsaturated |Gx|+|Gy|
    function automatic int exp_pix(input int mag);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= thr) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    function automatic int sobel_mag(input logic [MB-1:0] m);
        int p[8];
        int gx, gy;
        for (int i = 0; i < 8; i++) p[i] = int'(m[MB-1-8*i -: 8]);
        gx = (p[2] + 2*p[4] + p[7]) - (p[0] + 2*p[3] + p[5]);
        gy = (p[5] + 2*p[6] + p[7]) - (p[0] + 2*p[1] + p[2]);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    // One isolated matrix: no output for 2 cycles, then exactly one valid pixel
    task automatic single(input string tag, input int c, input int r, input logic [MB-1:0] m, input int mag);
        drive(c, r, m);
        tick();
        idle();
        check({tag, "_v1"}, 32'(O_PIXEL_VALID), 0);
        tick();
        check({tag, "_v2"}, 32'(O_PIXEL_VALID), 0);
        tick();
        check({tag, "_v3"}, 32'(O_PIXEL_VALID), 1);
        check({tag, "_pix"}, 32'(O_PIXEL), 32'(exp_pix(mag)));
        check({tag, "_col"}, 32'(O_PIXEL_COLUMN), 32'(c + 1));
        check({tag, "_row"}, 32'(O_PIXEL_ROW), 32'(r + 1));
        tick();
        check({tag, "_v4"}, 32'(O_PIXEL_VALID), 0);
    endtask

    typedef struct {
        int due;
        int col;
        int row;
        int pix;
        bit last;
    } exp_t;

    exp_t q[$];

    initial begin
        logic [MB-1:0] diag;
        exp_t e;
        int idx, n_out, n_done, n_err, budget;

        I_RESET              = 1'b1;
        I_PIXEL_COLUMN       = '0;
        I_PIXEL_ROW          = '0;
        I_PIXEL_MATRIX       = '0;
        I_PIXEL_MATRIX_READY = 1'b0;
        diag = pack(0, 0, 20, 0, 20, 20, 20, 20);

        do_reset();
        check("rst_valid", 32'(O_PIXEL_VALID), 0);
        check("rst_pixel", 32'(O_PIXEL), 0);
        check("rst_col",   32'(O_PIXEL_COLUMN), 0);
        check("rst_row",   32'(O_PIXEL_ROW), 0);
        check("rst_done",  32'(O_FRAME_DONE), 0);
        check("rst_err",   32'(O_SEQ_ERROR), 0);

        single("uniform", 0, 0, pack(100, 100, 100, 100, 100, 100, 100, 100), 0);
        single("vedge", 10, 5, pack(0, 0, 255, 0, 255, 0, 0, 255), 1020);
        thr = 121;
        single("diag_t121", 0, 0, diag, 120);
        thr = 120;
        single("diag_t120", 0, 0, diag, 120);
        thr = 1;
        single("neg_gx", 0, 0, pack(50, 0, 0, 50, 0, 50, 0, 0), 200);
        single("mag254", 0, 0, pack(0, 0, 0, 0, 127, 0, 0, 0), 254);
        single("mag256", 0, 0, pack(0, 0, 0, 0, 128, 0, 0, 0), 256);

        // Inputs outside the valid region produce no output
        drive(NCOL, 3, diag);
        tick();
        idle();
        tick();
        tick();
        check("oor_col_v3", 32'(O_PIXEL_VALID), 0);
        drive(5, NROW, diag);
        tick();
        idle();
        tick();
        tick();
        check("oor_row_v3", 32'(O_PIXEL_VALID), 0);

        // Sequence error: walk in order up to (4,2), then skip to (6,2)
        do_reset();
        for (int r = 0; r <= 2; r++) begin
            for (int c = 0; c < NCOL; c++) begin
                if (r == 2 && c > 4) break;
                drive(c, r, diag);
                tick();
            end
        end
        check("seq_inorder", 32'(O_SEQ_ERROR), 0);
        drive(6, 2, diag);
        tick();
        check("seq_skip", 32'(O_SEQ_ERROR), 1);
        drive(0, 0, diag);
        tick();
        idle();
        tick();
        check("seq_sticky", 32'(O_SEQ_ERROR), 1);
        do_reset();
        check("seq_cleared", 32'(O_SEQ_ERROR), 0);

        // Reset with matrices in flight and a simultaneous input
        drive(0, 0, diag);
        tick();
        drive(1, 0, diag);
        tick();
        drive(2, 0, diag);
        tick();
        check("flush_pre_valid", 32'(O_PIXEL_VALID), 1);
        I_RESET = 1'b1;
        drive(3, 0, diag);
        tick();
        I_RESET = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            check("flush_valid", 32'(O_PIXEL_VALID), 0);
            check("flush_pixel", 32'(O_PIXEL), 0);
            check("flush_col",   32'(O_PIXEL_COLUMN), 0);
            check("flush_done",  32'(O_FRAME_DONE), 0);
            tick();
        end
        single("post_flush", 0, 0, diag, 120);
        check("post_flush_err", 32'(O_SEQ_ERROR), 0);

        // Full raster with random bubbles, scoreboarded
        do_reset();
        idx = 0;
        n_out = 0;
        n_done = 0;
        n_err = 0;
        budget = 0;
        while ((idx < NCOL * NROW || q.size() > 0) && budget < 2000) begin
            budget++;
            if (O_SEQ_ERROR) n_err++;
            if (O_FRAME_DONE) n_done++;
            if (O_PIXEL_VALID) begin
                n_out++;
                if (q.size() == 0) begin
                    check("ras_unexpected", 32'(O_PIXEL_VALID), 0);
                end else begin
                    e = q.pop_front();
                    check("ras_latency", 32'(cyc), 32'(e.due));
                    check("ras_col",     32'(O_PIXEL_COLUMN), 32'(e.col));
                    check("ras_row",     32'(O_PIXEL_ROW), 32'(e.row));
                    check("ras_pix",     32'(O_PIXEL), 32'(e.pix));
                    check("ras_done",    32'(O_FRAME_DONE), 32'(e.last));
                end
            end else begin
                check("ras_done_novalid", 32'(O_FRAME_DONE), 0);
                if (q.size() > 0 && cyc > q[0].due) begin
                    e = q.pop_front();
                    check("ras_missing", 32'(cyc), 32'(e.due));
                end
            end
            if (idx < NCOL * NROW && $urandom_range(0, 3) != 0) begin
                logic [MB-1:0] m;
                if ($urandom_range(0, 1) == 1) begin
                    m = {$urandom, $urandom};
                end else begin
                    for (int k = 0; k < 8; k++) m[8*k +: 8] = 8'(40 + $urandom_range(0, 15));
                end
                e.due  = cyc + 3;
                e.col  = (idx % NCOL) + 1;
                e.row  = (idx / NCOL) + 1;
                e.pix  = exp_pix(sobel_mag(m));
                e.last = (idx == NCOL * NROW - 1);
                q.push_back(e);
                drive(idx % NCOL, idx / NCOL, m);
                idx++;
            end else begin
                idle();
            end
            tick();
        end
        check("ras_finished", 32'(budget < 2000), 1);
        check("ras_count", 32'(n_out), 32'(NCOL * NROW));
        check("ras_done_count", 32'(n_done), 1);
        check("ras_seq_err", 32'(n_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
